pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
//  - Merges three stall sources into one set of IF/ID/PC/ID-EX controls:
//    - the load-use hazard flag,
//    - a multi-cycle MUL/DIV unit, sequenced here by an internal latency counter,
//    - branch-taken flushes.
//  - Sits beside the hazard detection unit.
//  - Drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX bubble mux select.
// PARAMETERS
//  MD_LATENCY  32  cycles from MUL/DIV issue to result valid; legal range 1..2**CNT_W
//  CNT_W       8   width of the internal MUL/DIV latency counter
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst_n         in   1      asynchronous reset, active-low
//  init          in   1      startup window: all hazard actions suppressed
//  load_use      in   1      load-use hazard from hazard detection (same cycle)
//  md_req        in   1      instruction in ID is MUL/DIV, wants to issue
//  md_dep        in   1      instruction in ID reads HI/LO or a pending MUL/DIV result
//  branch_taken  in   1      branch/jump resolved taken this cycle
//  pc_write      out  1      PC write enable
//  ifid_write    out  1      IF/ID register write enable
//  ifid_flush    out  1      clear IF/ID to NOP
//  idex_bubble   out  1      select zero control word into ID/EX
//  md_busy       out  1      MUL/DIV operation in flight
//  md_done       out  1      one-cycle pulse: MUL/DIV result valid this cycle
//  stall_cnt     out  32     stall-cycle count (see CONFIGURATION)
//  flush_cnt     out  32     flush-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - State machine, two states:
//    - RUN: no MUL/DIV in flight.
//    - BUSY: MUL/DIV in flight; down-counter cnt is running.
//  - Reset (rst_n=0, async):
//    - state=RUN, cnt=0, statistics counters=0.
//    - Outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, md_busy=0, md_done=0.
//  - All outputs are combinational from the registered state, cnt and the current inputs.
//    - Zero added latency: a hazard is acted on in the same cycle it is flagged.
//  - Combinational terms:
//    - md_done = (state==BUSY) & (cnt==0)
//    - md_busy = (state==BUSY)
//    - blk     = md_busy & ~md_done & (md_req | md_dep)
//    - stall   = (load_use | blk) & ~branch_taken & ~init
//    - flush   = branch_taken & ~init
//    - pc_write = ifid_write = ~stall
//    - ifid_flush = flush
//    - idex_bubble = stall | flush
//    - accept  = md_req & ~stall & ~flush & ~init
//  - Priority: init > branch_taken > stall.
//    - A taken branch squashes the stalled ID instruction, so the stall is dropped.
//  - Transitions:
//    - RUN, accept: cnt <= MD_LATENCY-1; go to BUSY.
//    - BUSY, cnt!=0: cnt <= cnt-1.
//    - BUSY, cnt==0, accept: cnt <= MD_LATENCY-1; stay BUSY (back-to-back issue).
//    - BUSY, cnt==0, no accept: go to RUN.
//  - Timing: issue accepted at cycle t gives md_busy over t+1..t+MD_LATENCY and md_done at t+MD_LATENCY.
//    - A dependent instruction stalls MD_LATENCY-1 cycles. It is released in the md_done cycle (result forwarded).
//  - MD_LATENCY=1: BUSY lasts exactly one cycle, and that cycle has md_done=1. No MUL/DIV stall is ever generated.
//  - branch_taken while BUSY:
//    - IF/ID is flushed; the in-flight MUL/DIV is not cancelled.
//    - cnt keeps counting.
//    - md_req in the same cycle is not accepted.
//  - init=1 (synchronous on state):
//    - Next edge forces state=RUN, cnt=0.
//    - Outputs are immediately pc_write=ifid_write=1, flush/bubble=0.
//  - Reset mid-operation abandons the counter. No md_done is produced for the lost operation.
// CONFIGURATION
//  - Macro STALL_STATS_EN defined:
//    - stall_cnt increments on every cycle with stall=1.
//    - flush_cnt increments on every cycle with flush=1.
//    - Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on reset only.
//  - Macro STALL_STATS_EN undefined:
//    - No counter flops; stall_cnt and flush_cnt are tied to 0.
//    - Ports stay present so instantiations are unchanged.
// TESTING
//  - Reset: rst_n=0 mid-cycle -> immediately pc_write=1, ifid_write=1, idex_bubble=0, md_busy=0.
//  - Load-use: load_use=1 for 1 cycle in RUN -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle only.
//  - MUL/DIV dependency: MD_LATENCY=4, md_req at t, md_dep held from t+1 -> stall t+1..t+3, md_done at t+4, pc_write=1 at t+4.
//  - Back-to-back: md_req at t and held -> blocked t+1..t+3; accepted at t+4 with md_done=1; md_busy stays 1 and second md_done at t+8.
//  - Branch priority: branch_taken=1 with load_use=1 and md_dep=1 during BUSY -> ifid_flush=1, idex_bubble=1, pc_write=1; cnt unaffected.
//  - Init and stats: init=1 with load_use=1 -> pc_write=1, no bubble. With STALL_STATS_EN, 3 stall cycles and 1 flush cycle -> stall_cnt=3, flush_cnt=1.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the hazard logic and the pipeline stall/flush sequencer.
// The master drives the hazard flags; the slave (the sequencer) returns the pipeline controls.
interface pipeline_stall_ctrl_if;
   logic        init;
   logic        load_use;
   logic        md_req;
   logic        md_dep;
   logic        branch_taken;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_bubble;
   logic        md_busy;
   logic        md_done;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      output init, load_use, md_req, md_dep, branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done,
      input  stall_cnt, flush_cnt
   );

   modport slave (
      input  init, load_use, md_req, md_dep, branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done,
      output stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: merges load-use, MUL/DIV latency and
// branch flushes. Define STALL_STATS_EN to build the saturating stall/flush statistics counters.
module pipeline_stall_ctrl #(
   parameter int MD_LATENCY = 32,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   pipeline_stall_ctrl_if.slave bus
);

   typedef enum logic {ST_RUN, ST_BUSY} state_t;

   localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(MD_LATENCY - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_next_cnt;

   logic w_md_busy;
   logic w_md_done;
   logic w_blk;
   logic w_stall;
   logic w_flush;
   logic w_accept;

   // Everything below is combinational on registered state so a hazard is acted on the cycle it is flagged.
   assign w_md_busy = (r_state == ST_BUSY);
   assign w_md_done = w_md_busy && (r_cnt == '0);
   assign w_blk     = w_md_busy && !w_md_done && (bus.md_req || bus.md_dep);
   assign w_stall   = (bus.load_use || w_blk) && !bus.branch_taken && !bus.init;
   assign w_flush   = bus.branch_taken && !bus.init;
   assign w_accept  = bus.md_req && !w_stall && !w_flush && !bus.init;

   assign bus.pc_write    = !w_stall;
   assign bus.ifid_write  = !w_stall;
   assign bus.ifid_flush  = w_flush;
   assign bus.idex_bubble = w_stall || w_flush;
   assign bus.md_busy     = w_md_busy;
   assign bus.md_done     = w_md_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      if (bus.init) begin
         w_next_state = ST_RUN;
         w_next_cnt   = '0;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (w_accept) begin
                  w_next_state = ST_BUSY;
                  w_next_cnt   = LP_RELOAD;
               end
            end
            ST_BUSY: begin
               if (r_cnt != '0) begin
                  w_next_cnt = r_cnt - CNT_W'(1);
               end else if (w_accept) begin
                  // Back-to-back issue in the result cycle keeps the unit busy.
                  w_next_cnt = LP_RELOAD;
               end else begin
                  w_next_state = ST_RUN;
               end
            end
            default: begin
               w_next_state = ST_RUN;
               w_next_cnt   = '0;
            end
         endcase
      end
   end

`ifdef STALL_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with MD_LATENCY=4; control vector packs
// {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done}.
module tb_pipeline_stall_ctrl;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [31:0] exp_s;
   logic [31:0] exp_f;

   pipeline_stall_ctrl_if bus();

   pipeline_stall_ctrl #(.MD_LATENCY(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] ctl();
      return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble, bus.md_busy, bus.md_done};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, apply inputs 1ns after the edge, check outputs 1ns later.
   task automatic step(input logic i_init, input logic i_lu, input logic i_req, input logic i_dep,
                       input logic i_br, input string tag, input logic [5:0] exp);
      @(posedge clk);
      #1;
      bus.init         = i_init;
      bus.load_use     = i_lu;
      bus.md_req       = i_req;
      bus.md_dep       = i_dep;
      bus.branch_taken = i_br;
      #1;
      chk(tag, {26'd0, ctl()}, {26'd0, exp});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.init = 1'b0; bus.load_use = 1'b0; bus.md_req = 1'b0; bus.md_dep = 1'b0; bus.branch_taken = 1'b0;
      #2;
      chk("reset_ctl", {26'd0, ctl()}, 32'h30);
      chk("reset_stall_cnt", bus.stall_cnt, 32'd0);
      chk("reset_flush_cnt", bus.flush_cnt, 32'd0);
      #16 rst_n = 1'b1;

      //   init lu  req dep br
      step(0, 0, 0, 0, 0, "idle",          6'b110000);
      step(0, 1, 0, 0, 0, "load_use",      6'b000100);
      step(0, 0, 0, 0, 0, "load_use_off",  6'b110000);

      step(0, 0, 1, 0, 0, "dep_issue",     6'b110000);
      step(0, 0, 0, 1, 0, "dep_stall1",    6'b000110);
      step(0, 0, 0, 1, 0, "dep_stall2",    6'b000110);
      step(0, 0, 0, 1, 0, "dep_stall3",    6'b000110);
      step(0, 0, 0, 1, 0, "dep_done",      6'b110011);
      step(0, 0, 0, 1, 0, "dep_run",       6'b110000);

      step(0, 0, 1, 0, 0, "b2b_issue",     6'b110000);
      step(0, 0, 1, 0, 0, "b2b_blk1",      6'b000110);
      step(0, 0, 1, 0, 0, "b2b_blk2",      6'b000110);
      step(0, 0, 1, 0, 0, "b2b_blk3",      6'b000110);
      step(0, 0, 1, 0, 0, "b2b_done1",     6'b110011);
      step(0, 0, 1, 0, 0, "b2b_blk4",      6'b000110);
      step(0, 0, 1, 0, 0, "b2b_blk5",      6'b000110);
      step(0, 0, 1, 0, 0, "b2b_blk6",      6'b000110);
      step(0, 0, 1, 0, 0, "b2b_done2",     6'b110011);

      step(0, 1, 0, 1, 1, "br_priority",   6'b111110);
      step(0, 0, 0, 0, 0, "br_cnt2",       6'b110010);
      step(0, 0, 0, 0, 0, "br_cnt1",       6'b110010);
      step(0, 0, 0, 0, 0, "br_done",       6'b110011);
      step(0, 0, 1, 0, 1, "br_req_run",    6'b111100);
      step(0, 0, 0, 0, 0, "br_no_accept",  6'b110000);

      step(0, 0, 1, 0, 0, "rst_issue",     6'b110000);
      step(0, 0, 0, 0, 0, "rst_busy",      6'b110010);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_ctl", {26'd0, ctl()}, 32'h30);
      chk("rst_mid_stall_cnt", bus.stall_cnt, 32'd0);
      #3 rst_n = 1'b1;
      step(0, 0, 0, 0, 0, "rst_lost1",     6'b110000);
      step(0, 0, 0, 0, 0, "rst_lost2",     6'b110000);
      step(0, 0, 0, 0, 0, "rst_lost3",     6'b110000);
      step(0, 0, 0, 0, 0, "rst_lost4",     6'b110000);

      step(1, 1, 0, 1, 1, "init_suppress", 6'b110000);
      step(1, 0, 1, 0, 0, "init_no_issue", 6'b110000);
      step(0, 0, 0, 0, 0, "init_stay_run", 6'b110000);
      step(0, 0, 1, 0, 0, "init_issue",    6'b110000);
      step(1, 0, 0, 1, 0, "init_busy",     6'b110010);
      step(0, 0, 0, 1, 0, "init_forced",   6'b110000);

      step(0, 1, 0, 0, 0, "stat_stall1",   6'b000100);
      step(0, 1, 0, 0, 0, "stat_stall2",   6'b000100);
      step(0, 1, 0, 0, 0, "stat_stall3",   6'b000100);
      step(0, 0, 0, 0, 1, "stat_flush",    6'b111100);
      step(0, 0, 0, 0, 0, "stat_idle",     6'b110000);
`ifdef STALL_STATS_EN
      exp_s = 32'd3;
      exp_f = 32'd1;
`else
      exp_s = 32'd0;
      exp_f = 32'd0;
`endif
      chk("stall_cnt", bus.stall_cnt, exp_s);
      chk("flush_cnt", bus.flush_cnt, exp_f);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
